// File: rtl/mpc_div_pkg.sv
// Shared widths, FSM encoding and saturation bounds for the MPC sequential divider.
package mpc_div_pkg;

    localparam int DIV_DW = 36;
    localparam int DIV_SW = 15;
    localparam int DIV_QW = 21;

    localparam logic signed [DIV_QW-1:0] QMAX = {1'b0, {(DIV_QW-1){1'b1}}};
    localparam logic signed [DIV_QW-1:0] QMIN = {1'b1, {(DIV_QW-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

endpackage

// File: rtl/mpc_div_restoring_step.sv
// One radix-2 restoring step: shift in a dividend bit, subtract divisor when it fits.
module mpc_div_restoring_step #(
    parameter int DW = 15
) (
    input  logic [DW-1:0] rem_in,
    input  logic          bit_in,
    input  logic [DW-1:0] divisor,
    output logic [DW-1:0] rem_out,
    output logic          q_bit
);

    logic [DW:0] shifted;
    logic [DW:0] diff;

    assign shifted = {rem_in, bit_in};
    assign diff    = shifted - {1'b0, divisor};
    assign q_bit   = (shifted >= {1'b0, divisor});
    // rem_in < divisor keeps the restored or reduced value inside DW bits
    assign rem_out = q_bit ? diff[DW-1:0] : shifted[DW-1:0];

endmodule

// File: rtl/mpc_div_36s_15ns_21s_seq.sv
// Sequential signed/unsigned restoring divider with saturated 21-bit quotient,
// start/done handshake and ce-gated registers; fixed latency of DIVIDEND_WIDTH+2.
module mpc_div_36s_15ns_21s_seq
    import mpc_div_pkg::*;
#(
    parameter int DIVIDEND_WIDTH = DIV_DW,
    parameter int DIVISOR_WIDTH  = DIV_SW,
    parameter int QUOTIENT_WIDTH = DIV_QW
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             ce,
    input  logic                             start,
    input  logic [DIVIDEND_WIDTH-1:0]        din0,
    input  logic [DIVISOR_WIDTH-1:0]         din1,
    output logic                             ready,
    output logic                             done,
    output logic signed [QUOTIENT_WIDTH-1:0] dout,
    output logic signed [DIVISOR_WIDTH:0]    rem,
    output logic                             ovf,
    output logic                             div_zero
);

    localparam int CW = $clog2(DIVIDEND_WIDTH);
    localparam logic [CW-1:0] LAST = CW'(DIVIDEND_WIDTH - 1);
    localparam logic [DIVIDEND_WIDTH-1:0] QMAX_MAG =
        DIVIDEND_WIDTH'((64'd1 << (QUOTIENT_WIDTH - 1)) - 64'd1);
    localparam logic [DIVIDEND_WIDTH-1:0] QMIN_MAG =
        DIVIDEND_WIDTH'(64'd1 << (QUOTIENT_WIDTH - 1));
    localparam logic [QUOTIENT_WIDTH-1:0] SAT_HI = {1'b0, {(QUOTIENT_WIDTH-1){1'b1}}};
    localparam logic [QUOTIENT_WIDTH-1:0] SAT_LO = {1'b1, {(QUOTIENT_WIDTH-1){1'b0}}};

    div_state_e state, state_nx;

    logic [CW-1:0]             cnt;
    logic                      neg;
    logic                      dz_r;
    logic [DIVIDEND_WIDTH-1:0] dvd;
    logic [DIVISOR_WIDTH-1:0]  dvs;
    logic [DIVISOR_WIDTH-1:0]  prem;

    logic [DIVISOR_WIDTH-1:0]  step_rem;
    logic                      step_q;

    logic [QUOTIENT_WIDTH-1:0] q_lo;
    logic [DIVISOR_WIDTH:0]    rem_ext;
    logic [QUOTIENT_WIDTH-1:0] fix_dout;
    logic [DIVISOR_WIDTH:0]    fix_rem;
    logic                      fix_ovf;

    mpc_div_restoring_step #(
        .DW (DIVISOR_WIDTH)
    ) u_step (
        .rem_in  (prem),
        .bit_in  (dvd[DIVIDEND_WIDTH-1]),
        .divisor (dvs),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    assign ready = (state == IDLE);
    assign done  = (state == DONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (ce) begin
            case (state)
                IDLE:    if (start) state_nx = ITER;
                ITER:    if (cnt == LAST) state_nx = FIX;
                FIX:     state_nx = DONE;
                DONE:    state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    // After the last step dvd holds the unsigned quotient and prem the remainder
    assign q_lo    = dvd[QUOTIENT_WIDTH-1:0];
    assign rem_ext = {1'b0, prem};

    always_comb begin
        fix_dout = neg ? (~q_lo + 1'b1) : q_lo;
        fix_rem  = neg ? (~rem_ext + 1'b1) : rem_ext;
        fix_ovf  = 1'b0;
        if (dz_r) begin
            fix_dout = neg ? SAT_LO : SAT_HI;
            fix_rem  = '0;
        end else if (!neg && (dvd > QMAX_MAG)) begin
            fix_dout = SAT_HI;
            fix_ovf  = 1'b1;
        end else if (neg && (dvd > QMIN_MAG)) begin
            fix_dout = SAT_LO;
            fix_ovf  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt      <= '0;
            neg      <= 1'b0;
            dz_r     <= 1'b0;
            dvd      <= '0;
            dvs      <= '0;
            prem     <= '0;
            dout     <= '0;
            rem      <= '0;
            ovf      <= 1'b0;
            div_zero <= 1'b0;
        end else if (ce) begin
            case (state)
                IDLE: begin
                    if (start) begin
                        // magnitude of the most negative value is representable unsigned
                        neg  <= din0[DIVIDEND_WIDTH-1];
                        dvd  <= din0[DIVIDEND_WIDTH-1] ? (~din0 + 1'b1) : din0;
                        dvs  <= din1;
                        dz_r <= (din1 == '0);
                        prem <= '0;
                        cnt  <= '0;
                    end
                end
                ITER: begin
                    dvd  <= {dvd[DIVIDEND_WIDTH-2:0], step_q};
                    prem <= step_rem;
                    cnt  <= cnt + 1'b1;
                end
                FIX: begin
                    dout     <= fix_dout;
                    rem      <= fix_rem;
                    ovf      <= fix_ovf;
                    div_zero <= dz_r;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mpc_div_36s_15ns_21s_seq.sv
// Self-checking bench: arithmetic reference model, scoreboard queue, per-cycle compare.
module tb_mpc_div_36s_15ns_21s_seq;

    localparam int  LAT    = 38;
    localparam longint QHI = 1048575;
    localparam longint QLO = -1048576;

    typedef struct {
        logic signed [20:0] dout;
        logic signed [15:0] rem;
        logic               ovf;
        logic               dz;
        int                 acc;
    } exp_t;

    logic               clk = 1'b0;
    logic               reset;
    logic               ce;
    logic               start;
    logic [35:0]        din0;
    logic [14:0]        din1;
    logic               ready;
    logic               done;
    logic signed [20:0] dout;
    logic signed [15:0] rem;
    logic               ovf;
    logic               div_zero;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_done  = 0;
    int   ce_idx  = 0;
    exp_t sb[$];
    exp_t last;

    mpc_div_36s_15ns_21s_seq dut (
        .clk      (clk),
        .reset    (reset),
        .ce       (ce),
        .start    (start),
        .din0     (din0),
        .din1     (din1),
        .ready    (ready),
        .done     (done),
        .dout     (dout),
        .rem      (rem),
        .ovf      (ovf),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
        end
    endtask

    // Truncating signed division, then saturation to the 21-bit range
    function automatic exp_t model(input logic [35:0] a_raw, input logic [14:0] b_raw);
        exp_t   e;
        longint a, b, q, r;
        a = longint'($signed(a_raw));
        b = longint'(b_raw);
        e.acc = 0;
        e.ovf = 1'b0;
        e.dz  = 1'b0;
        if (b == 0) begin
            e.dz   = 1'b1;
            e.dout = (a < 0) ? 21'(QLO) : 21'(QHI);
            e.rem  = '0;
        end else begin
            q = a / b;
            r = a % b;
            e.rem = 16'(r);
            if (q > QHI) begin
                e.dout = 21'(QHI);
                e.ovf  = 1'b1;
            end else if (q < QLO) begin
                e.dout = 21'(QLO);
                e.ovf  = 1'b1;
            end else begin
                e.dout = 21'(q);
            end
        end
        return e;
    endfunction

    // Compare process: sampled on the falling edge, inputs are stable for the next rising edge
    always @(negedge clk) begin
        bit   idle;
        exp_t e;
        if (!reset) begin
            sb.delete();
            last = '{dout: '0, rem: '0, ovf: 1'b0, dz: 1'b0, acc: 0};
            chk("rst_ready", ready, 1);
            chk("rst_done", done, 0);
        end else begin
            idle = (sb.size() == 0);
            chk("ready", ready, idle);
            if (done) begin
                if (idle) begin
                    chk("spurious_done", done, 0);
                end else begin
                    last = sb[0];
                    if (ce) begin
                        chk("latency", ce_idx - sb[0].acc, LAT);
                        void'(sb.pop_front());
                        n_done++;
                    end
                end
            end
            if (ce && start && idle) begin
                e     = model(din0, din1);
                e.acc = ce_idx;
                sb.push_back(e);
            end
            if (ce) ce_idx++;
        end
        chk("dout", dout, last.dout);
        chk("rem", rem, last.rem);
        chk("ovf", ovf, last.ovf);
        chk("div_zero", div_zero, last.dz);
    end

    task automatic do_op(input longint a, input longint b, input bit thr);
        int n0;
        n0 = n_done;
        @(posedge clk); #1;
        ce    = 1'b1;
        start = 1'b1;
        din0  = 36'(a);
        din1  = 15'(b);
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 400 && n_done == n0; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (thr) begin
                ce = 1'($urandom_range(0, 1));
                if (k == 5) begin
                    start = 1'b1;
                    din0  = 36'd77;
                    din1  = 15'd3;
                end
            end
        end
        ce = 1'b1;
        if (n_done == n0) chk("op_timeout", n_done, n0 + 1);
    endtask

    task automatic lit(input string nm, input longint d, input longint r,
                       input logic o, input logic z);
        chk({nm, "_dout"}, dout, d);
        chk({nm, "_rem"}, rem, r);
        chk({nm, "_ovf"}, ovf, o);
        chk({nm, "_dz"}, div_zero, z);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [35:0] raw;
        longint      a, b;
        int          n0;
        reset = 1'b0;
        ce    = 1'b0;
        start = 1'b0;
        din0  = '0;
        din1  = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        ce    = 1'b1;
        @(posedge clk); #1;

        do_op(1000, 7, 0);                lit("p1000_7", 142, 6, 0, 0);
        do_op(-1000, 7, 0);               lit("n1000_7", -142, -6, 0, 0);
        do_op(-7, 1000, 0);               lit("n7_1000", 0, -7, 0, 0);
        do_op(64'sd1 << 34, 1, 0);        lit("big_pos", 1048575, 0, 1, 0);
        do_op(-(64'sd1 << 35), 3, 0);     lit("min_div3", -1048576, -2, 1, 0);
        do_op(-1048576, 1, 0);            lit("qmin_exact", -1048576, 0, 0, 0);
        do_op(-5, 0, 0);                  lit("n5_zero", -1048576, 0, 0, 1);
        do_op(5, 0, 0);                   lit("p5_zero", 1048575, 0, 0, 1);
        do_op(0, 9, 0);                   lit("zero_dvd", 0, 0, 0, 0);
        do_op(1000, 7, 1);                lit("thr_1000_7", 142, 6, 0, 0);

        // abort mid-iteration
        n0 = n_done;
        @(posedge clk); #1;
        start = 1'b1; din0 = 36'd1000; din1 = 15'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        lit("abort", 0, 0, 0, 0);
        chk("abort_ready", ready, 1);
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (60) @(posedge clk);
        #1;
        chk("abort_no_done", n_done, n0);
        do_op(1000, 7, 0);                lit("post_abort", 142, 6, 0, 0);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 2))
                0: raw = 36'({$urandom(), $urandom()});
                1: raw = 36'(longint'($urandom_range(0, 4000)) - 2000);
                default: begin
                    raw = 36'({$urandom(), $urandom()}) >> $urandom_range(0, 35);
                    if ($urandom_range(0, 1) == 1) raw = ~raw + 1'b1;
                end
            endcase
            case ($urandom_range(0, 7))
                0:       b = 0;
                1, 2, 3: b = $urandom_range(1, 15);
                default: b = $urandom_range(1, 32767);
            endcase
            a = longint'($signed(raw));
            do_op(a, b, 1'($urandom_range(0, 1)));
        end

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
